omsp_atomic_budget_ctrl: RTL and testbench

//  Admission controller in front of the atomicity monitor. Rations atomic (interrupt-masked) time per SM-visible window.

---
 rtl/omsp_atom_pkg.sv | 25 ++
 rtl/omsp_atom_window_timer.sv | 36 +++
 rtl/omsp_atomic_budget_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_omsp_atomic_budget_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/omsp_atom_pkg.sv
// Shared definitions for the atomic-section budget controller.
//  - atom_state_e : FSM state encoding, also exported on the debug state port
//  - *_DEF        : default parameter values for the controller and window timer
//  - max_u        : helper for sizing the shared cooldown/timeout counter
package omsp_atom_pkg;

  localparam int unsigned LEN_W_DEF    = 16;
  localparam int unsigned WINDOW_DEF   = 64;
  localparam int unsigned BUDGET_DEF   = 16;
  localparam int unsigned COOLDOWN_DEF = 4;
  localparam int unsigned TIMEOUT_DEF  = 2;

  // Encoding 2'd3 is unreachable in normal operation and falls back to idle.
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StActive   = 2'd1,
    StCooldown = 2'd2,
    StRsvd     = 2'd3
  } atom_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/omsp_atom_window_timer.sv
// Free-running replenish timer for the atomic-cycle budget.
// Counts down from WINDOW-1 to 0 and reloads; o_refill is high for the single
// cycle in which the count is 0.
//  i_mclk       core clock
//  i_puc_rst_n  synchronous active-low reset (count reloads to WINDOW-1)
//  o_refill     one-cycle pulse once per WINDOW cycles
module omsp_atom_window_timer
  import omsp_atom_pkg::*;
#(
  parameter int unsigned WINDOW = WINDOW_DEF
) (
  input  logic i_mclk,
  input  logic i_puc_rst_n,
  output logic o_refill
);

  localparam int unsigned CntW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WINDOW - 1);

  logic [CntW-1:0] r_win_cnt;
  logic [CntW-1:0] w_win_cnt_d;

  always_comb begin
    o_refill    = (r_win_cnt == '0);
    w_win_cnt_d = o_refill ? CntLast : (r_win_cnt - CntW'(1));
  end

  always_ff @(posedge i_mclk) begin
    if (!i_puc_rst_n) begin
      r_win_cnt <= CntLast;
    end else begin
      r_win_cnt <= w_win_cnt_d;
    end
  end

endmodule

// File: rtl/omsp_atomic_budget_ctrl.sv
// Admission controller for clix atomic sections.
// Grants clix requests only while the per-window atomic-cycle budget allows,
// and forces a GIE-open cooldown after every section so pending interrupts are
// serviced before the next grant.
//  i_mclk            core clock
//  i_puc_rst_n       synchronous active-low reset
//  i_clix_req        clix decoded; held until grant or budget error
//  i_clix_len        requested atomic length (r15 slice)
//  i_atom_active     monitor is inside an atomic section (clix or SM entry)
//  i_irq_pending     pending interrupt, informational only
//  o_clix_grant      one-cycle grant pulse to the monitor
//  o_clix_stall      hold the frontend while the request waits
//  o_budget_err      request can never fit in a full window budget
//  o_budget_overrun  atomic cycle charged against an empty budget
//  o_budget_left     remaining atomic cycles in the current window
//  o_state           FSM state for trace
module omsp_atomic_budget_ctrl
  import omsp_atom_pkg::*;
#(
  parameter int unsigned LEN_W    = LEN_W_DEF,
  parameter int unsigned WINDOW   = WINDOW_DEF,
  parameter int unsigned BUDGET   = BUDGET_DEF,
  parameter int unsigned COOLDOWN = COOLDOWN_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             i_mclk,
  input  logic             i_puc_rst_n,
  input  logic             i_clix_req,
  input  logic [LEN_W-1:0] i_clix_len,
  input  logic             i_atom_active,
  input  logic             i_irq_pending,
  output logic             o_clix_grant,
  output logic             o_clix_stall,
  output logic             o_budget_err,
  output logic             o_budget_overrun,
  output logic [LEN_W-1:0] o_budget_left,
  output logic [1:0]       o_state
);

  // Shared counter: timeout in ACTIVE, cooldown length in COOLDOWN.
  localparam int unsigned CntMax = max_u(max_u(COOLDOWN, TIMEOUT), 1);
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] CdLast = CntW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam logic [CntW-1:0] ToLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit HasCooldown = (COOLDOWN != 0);

  // Cost is len+1 compared one bit wider so len = all-ones cannot wrap.
  localparam int unsigned CostW = LEN_W + 1;
  localparam logic [CostW-1:0] BudgetCost = CostW'(BUDGET);
  localparam logic [LEN_W-1:0] BudgetFull = LEN_W'(BUDGET);

  atom_state_e      r_state;
  atom_state_e      w_state_d;
  logic [CntW-1:0]  r_cnt;
  logic [CntW-1:0]  w_cnt_d;
  logic             r_seen;
  logic             w_seen_d;
  logic [LEN_W-1:0] r_budget_left;
  logic [LEN_W-1:0] w_budget_d;

  logic             w_refill;
  logic             w_overrun;
  logic [CostW-1:0] w_cost;
  logic             w_too_big;
  logic             w_fits;
  logic             w_irq_unused;

  // Cooldown length is fixed; a pending interrupt never shortens it.
  assign w_irq_unused = i_irq_pending;

  omsp_atom_window_timer #(
    .WINDOW (WINDOW)
  ) u_win_timer (
    .i_mclk      (i_mclk),
    .i_puc_rst_n (i_puc_rst_n),
    .o_refill    (w_refill)
  );

  assign w_cost    = {1'b0, i_clix_len} + CostW'(1);
  assign w_too_big = (w_cost > BudgetCost);
  // Registered budget: a request in the refill cycle is granted one cycle later.
  assign w_fits    = (w_cost <= {1'b0, r_budget_left});

  // Budget counter: charged in every state, SM-entry sections included.
  // On a refill cycle the refill wins and the charge goes to the new window.
  always_comb begin
    w_budget_d = r_budget_left;
    w_overrun  = 1'b0;
    if (w_refill) begin
      w_budget_d = i_atom_active ? (BudgetFull - LEN_W'(1)) : BudgetFull;
    end else if (i_atom_active) begin
      if (r_budget_left != '0) begin
        w_budget_d = r_budget_left - LEN_W'(1);
      end else begin
        w_overrun = 1'b1;
      end
    end
  end

  always_ff @(posedge i_mclk) begin
    if (!i_puc_rst_n) begin
      r_budget_left <= BudgetFull;
    end else begin
      r_budget_left <= w_budget_d;
    end
  end

  // FSM state register.
  always_ff @(posedge i_mclk) begin
    if (!i_puc_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_seen  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_seen  <= w_seen_d;
    end
  end

  // FSM next state.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_seen_d  = r_seen;
    case (r_state)
      StIdle: begin
        w_cnt_d  = '0;
        w_seen_d = 1'b0;
        if (i_clix_req && !w_too_big && w_fits) begin
          w_state_d = StActive;
        end
      end
      StActive: begin
        if (i_atom_active) begin
          w_seen_d = 1'b1;
        end
        if (!r_seen) begin
          w_cnt_d = r_cnt + CntW'(1);
        end
        // Section finished, or the monitor never opened one (e.g. nested clix).
        if ((r_seen && !i_atom_active) ||
            (!r_seen && !i_atom_active && (r_cnt == ToLast))) begin
          w_state_d = HasCooldown ? StCooldown : StIdle;
          w_cnt_d   = '0;
          w_seen_d  = 1'b0;
        end
      end
      StCooldown: begin
        if (r_cnt == CdLast) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
        w_seen_d  = 1'b0;
      end
    endcase
  end

  // FSM outputs. Pulses are masked while reset is asserted so nothing is
  // granted in the reset cycle.
  always_comb begin
    o_clix_grant = 1'b0;
    o_clix_stall = 1'b0;
    o_budget_err = 1'b0;
    if (i_puc_rst_n) begin
      case (r_state)
        StIdle: begin
          if (i_clix_req) begin
            if (w_too_big) begin
              o_budget_err = 1'b1;
            end else if (w_fits) begin
              o_clix_grant = 1'b1;
            end else begin
              o_clix_stall = 1'b1;
            end
          end
        end
        StActive, StCooldown: begin
          o_clix_stall = i_clix_req;
        end
        default: begin
          o_clix_stall = 1'b0;
        end
      endcase
    end
  end

  assign o_budget_overrun = i_puc_rst_n & w_overrun;
  assign o_budget_left    = r_budget_left;
  assign o_state          = r_state;

endmodule

// File: tb/tb_omsp_atomic_budget_ctrl.sv
// Directed bench for omsp_atomic_budget_ctrl with default parameters
// (WINDOW=64, BUDGET=16, COOLDOWN=4, TIMEOUT=2). Cycle index n counts posedges
// since the last reset edge; the window refills in cycles with n%64 == 63.
module tb_omsp_atomic_budget_ctrl;

  logic        mclk;
  logic        rst_n;
  logic        req;
  logic [15:0] len;
  logic        act;
  logic        irq;
  logic        grant;
  logic        stall;
  logic        err;
  logic        ovr;
  logic [15:0] left;
  logic [1:0]  state;

  int n;
  int n_checks;
  int n_errors;
  int ovr_cnt;

  omsp_atomic_budget_ctrl dut (
    .i_mclk           (mclk),
    .i_puc_rst_n      (rst_n),
    .i_clix_req       (req),
    .i_clix_len       (len),
    .i_atom_active    (act),
    .i_irq_pending    (irq),
    .o_clix_grant     (grant),
    .o_clix_stall     (stall),
    .o_budget_err     (err),
    .o_budget_overrun (ovr),
    .o_budget_left    (left),
    .o_state          (state)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  task automatic tick();
    @(posedge mclk);
    #1;
    n++;
  endtask

  task automatic goto(input int target);
    while (n < target) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d (n=%0d)", tag, obs, exp, n);
    end
  endtask

  initial begin
    n = 0; n_checks = 0; n_errors = 0; ovr_cnt = 0;
    rst_n = 1'b0; req = 1'b0; len = '0; act = 1'b0; irq = 1'b0;
    tick();
    tick();
    n = 0;
    rst_n = 1'b1;
    #1;
    check("rst_state", state, 0);
    check("rst_budget", left, 16);
    check("rst_grant", grant, 0);
    check("rst_stall", stall, 0);
    check("rst_err", err, 0);
    check("rst_ovr", ovr, 0);

    // len=5 granted in the same cycle from idle
    req = 1'b1; len = 16'd5; #1;
    check("t1_grant", grant, 1);
    check("t1_nostall", stall, 0);
    check("t1_noerr", err, 0);
    tick();                                   // n=1
    req = 1'b0; act = 1'b1; #1;
    check("t1_active", state, 1);
    check("t1_grant_drop", grant, 0);
    goto(7);
    act = 1'b0; #1;
    check("t1_budget10", left, 10);
    check("t1_still_active", state, 1);

    // second request (len=9) during cooldown stalls 4 cycles
    tick();                                   // n=8
    req = 1'b1; len = 16'd9; #1;
    check("t2_cd_state", state, 2);
    check("t2_cd_stall", stall, 1);
    check("t2_cd_nogrant", grant, 0);
    goto(11);
    check("t2_cd_last_state", state, 2);
    check("t2_cd_last_stall", stall, 1);
    tick();                                   // n=12
    check("t2_idle", state, 0);
    check("t2_grant", grant, 1);
    check("t2_grant_nostall", stall, 0);
    check("t2_budget", left, 10);
    tick();                                   // n=13
    req = 1'b0; act = 1'b1; #1;
    check("t2_active", state, 1);
    goto(18);
    check("t2_budget5", left, 5);
    goto(23);
    act = 1'b0; #1;
    check("t2_budget0", left, 0);
    check("t2_no_ovr", ovr, 0);

    // cost 17 can never fit; cost 16 is legal but must wait
    goto(28);
    check("t4_idle", state, 0);
    req = 1'b1; len = 16'd16; #1;
    check("t4_err", err, 1);
    check("t4_nogrant", grant, 0);
    check("t4_nostall", stall, 0);
    tick();                                   // n=29
    len = 16'd15; #1;
    check("t4_stay_idle", state, 0);
    check("t4_cost16_noerr", err, 0);
    check("t4_cost16_stall", stall, 1);
    tick();                                   // n=30
    req = 1'b0; #1;
    check("t4_release", stall, 0);

    // len=12 waits for refill at n=63, granted at n=64
    tick();                                   // n=31
    req = 1'b1; len = 16'd12; #1;
    check("t3a_stall", stall, 1);
    goto(63);
    check("t3a_refill_stall", stall, 1);
    check("t3a_refill_nogrant", grant, 0);
    check("t3a_refill_budget", left, 0);
    tick();                                   // n=64
    check("t3a_grant", grant, 1);
    check("t3a_budget16", left, 16);
    tick();                                   // n=65
    req = 1'b0; act = 1'b1; #1;
    goto(78);
    act = 1'b0; #1;
    check("t3a_budget3", left, 3);

    // budget 3, len=7 stalls until refill at n=127, grant at n=128
    goto(83);
    check("t3b_idle", state, 0);
    req = 1'b1; len = 16'd7; #1;
    check("t3b_stall", stall, 1);
    check("t3b_nogrant", grant, 0);
    goto(127);
    check("t3b_refill_stall", stall, 1);
    check("t3b_refill_budget", left, 3);
    tick();                                   // n=128
    check("t3b_grant", grant, 1);
    check("t3b_budget16", left, 16);
    tick();                                   // n=129
    req = 1'b0; act = 1'b1; #1;
    goto(137);
    act = 1'b0; #1;
    check("t3b_budget8", left, 8);

    // grant without atom_active -> timeout to cooldown after 2 cycles
    goto(142);
    check("t5_idle", state, 0);
    req = 1'b1; len = 16'd2; #1;
    check("t5_grant", grant, 1);
    tick();                                   // n=143
    req = 1'b0; #1;
    check("t5_active0", state, 1);
    tick();                                   // n=144
    check("t5_active1", state, 1);
    tick();                                   // n=145
    irq = 1'b1; #1;
    check("t5_cooldown", state, 2);
    check("t5_budget_kept", left, 8);
    goto(148);
    check("t5_cd_full", state, 2);
    tick();                                   // n=149
    irq = 1'b0;
    check("t5_back_idle", state, 0);

    // long section drains the budget; overrun pulses once budget is 0
    req = 1'b1; len = 16'd3; #1;
    check("t6_grant", grant, 1);
    tick();                                   // n=150
    req = 1'b0; act = 1'b1; #1;
    repeat (15) begin
      if (ovr) ovr_cnt++;
      tick();
    end                                       // n=165
    check("t6_ovr_count", ovr_cnt, 7);
    check("t6_budget_sat", left, 0);

    // reset mid-section: no grant or pulse in the reset cycle
    rst_n = 1'b0; req = 1'b1; len = 16'd0; #1;
    check("t6_rst_nogrant", grant, 0);
    check("t6_rst_noovr", ovr, 0);
    check("t6_rst_nostall", stall, 0);
    tick();
    n = 0;
    rst_n = 1'b1; req = 1'b0; act = 1'b0; #1;
    check("t6_post_rst_state", state, 0);
    check("t6_post_rst_budget", left, 16);

    // refill cycle with atom_active: charge lands in the new window
    goto(60);
    act = 1'b1; #1;
    goto(63);
    check("t7_pre_refill", left, 13);
    check("t7_refill_noovr", ovr, 0);
    tick();                                   // n=64
    act = 1'b0; #1;
    check("t7_refill_charge", left, 15);
    check("t7_idle", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
